fir: RTL and testbench

FIR -- requirements
Module: fir

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_mac.sv | 35 +++
 rtl/fir.sv | 93 +++++++++
 tb/tb_fir.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR constants: widths, tap count, controller states and the quantized coefficient set.
package fir_pkg;

  localparam int IN_WIDTH   = 16;
  localparam int COEF_WIDTH = 16;
  localparam int TAPS       = 64;
  localparam int OUT_WIDTH  = IN_WIDTH + COEF_WIDTH + $clog2(TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // h[0] first; the main lobe sits at taps 31/32.
  localparam logic signed [COEF_WIDTH-1:0] COEFFS [TAPS] = '{
    16'sd12,     -16'sd25,    -16'sd41,    16'sd30,     16'sd88,     16'sd17,     -16'sd120,   -16'sd160,
    16'sd45,     16'sd260,    16'sd190,    -16'sd230,   -16'sd480,   -16'sd105,   16'sd520,    16'sd760,
    -16'sd18,    -16'sd990,   -16'sd1010,  16'sd420,    16'sd1800,   16'sd1130,   -16'sd1350,  -16'sd2900,
    -16'sd700,   16'sd3600,   16'sd4500,   -16'sd1200,  -16'sd8100,  -16'sd6200,  16'sd9800,   16'sd32767,
    16'sd32767,  16'sd9800,   -16'sd6200,  -16'sd8100,  -16'sd1200,  16'sd4500,   16'sd3600,   -16'sd700,
    -16'sd2900,  -16'sd1350,  16'sd1130,   16'sd1800,   16'sd420,    -16'sd1010,  -16'sd990,   -16'sd18,
    16'sd760,    16'sd520,    -16'sd105,   -16'sd480,   -16'sd230,   16'sd190,    16'sd260,    16'sd45,
    -16'sd160,   -16'sd120,   16'sd17,     16'sd88,     16'sd30,     -16'sd41,    -16'sd25,    16'sh8000
  };

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate: clear wins over enable, full-precision sum.
module fir_mac #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [P_W-1:0] p);
    return ACC_W'(p);
  endfunction

  logic signed [P_W-1:0] prod;

  assign prod = P_W'(a) * P_W'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + sext(prod);
  end

endmodule

// File: rtl/fir.sv
// Sequential single-multiplier FIR: one sample accepted per IDLE visit, one tap per cycle in MAC.
module fir
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = fir_pkg::IN_WIDTH,
  parameter int COEF_WIDTH = fir_pkg::COEF_WIDTH,
  parameter int TAPS       = fir_pkg::TAPS,
  parameter int OUT_WIDTH  = fir_pkg::OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  FIR_input,
  input  logic                        input_valid,
  output logic signed [OUT_WIDTH-1:0] FIR_output,
  output logic                        output_valid
);

  localparam int IDX_W = $clog2(TAPS);

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic signed [IN_WIDTH-1:0] x_dl [TAPS];
  logic signed [OUT_WIDTH-1:0] acc;
  logic accept, mac_en, load_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (input_valid) state_d = MAC;
      MAC:     if (idx == IDX_W'(TAPS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state_q == IDLE) && input_valid;
    mac_en   = (state_q == MAC);
    load_out = (state_q == DONE);
  end

  // Delay line only moves on accept, so it is stable for the whole MAC sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x_dl[k] <= '0;
    end else if (accept) begin
      x_dl[0] <= FIR_input;
      for (int k = 1; k < TAPS; k++) x_dl[k] <= x_dl[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx <= '0;
    else if (accept)
      idx <= '0;
    else if (mac_en)
      idx <= idx + 1'b1;
  end

  fir_mac #(
    .A_W   (COEF_WIDTH),
    .B_W   (IN_WIDTH),
    .ACC_W (OUT_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (mac_en),
    .a   (COEFFS[idx]),
    .b   (x_dl[idx]),
    .acc (acc)
  );

  // Output register holds between DONE visits; valid is a single-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FIR_output   <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= load_out;
      if (load_out) FIR_output <= acc;
    end
  end

endmodule

// File: tb/tb_fir.sv
// Directed bench for fir: table of samples with model-derived sums, plus handshake and reset sequences.
module tb_fir;

  localparam int TAPS = 64;
  localparam int LAT  = TAPS + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] FIR_input;
  logic               input_valid;
  logic signed [37:0] FIR_output;
  logic               output_valid;

  int checks = 0;
  int errors = 0;

  int h [TAPS] = '{
    12, -25, -41, 30, 88, 17, -120, -160,
    45, 260, 190, -230, -480, -105, 520, 760,
    -18, -990, -1010, 420, 1800, 1130, -1350, -2900,
    -700, 3600, 4500, -1200, -8100, -6200, 9800, 32767,
    32767, 9800, -6200, -8100, -1200, 4500, 3600, -700,
    -2900, -1350, 1130, 1800, 420, -1010, -990, -18,
    760, 520, -105, -480, -230, 190, 260, 45,
    -160, -120, 17, 88, 30, -41, -25, -32768
  };

  longint hist [TAPS];

  typedef struct {
    int                 grp;
    logic signed [15:0] x;
    longint             y;
  } vec_t;

  vec_t vecs[$];

  fir dut (
    .clk          (clk),
    .rst          (rst),
    .FIR_input    (FIR_input),
    .input_valid  (input_valid),
    .FIR_output   (FIR_output),
    .output_valid (output_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
  endfunction

  function automatic longint model_push(input longint x);
    longint s = 0;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    for (int k = 0; k < TAPS; k++) s += longint'(h[k]) * hist[k];
    return s;
  endfunction

  function automatic void add_vec(input int grp, input logic signed [15:0] x);
    vec_t v;
    v.grp = grp;
    v.x   = x;
    v.y   = model_push(longint'(x));
    vecs.push_back(v);
  endfunction

  // Called at a falling edge; leaves the bench at a falling edge with rst low.
  task automatic do_reset();
    input_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one sample, wait for its result; returns at the falling edge of the valid cycle.
  task automatic send(input logic signed [15:0] x, output logic signed [37:0] y, output int lat);
    FIR_input   = x;
    input_valid = 1'b1;
    lat = 0;
    @(posedge clk);
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (output_valid) break;
    end
    y = FIR_output;
    @(negedge clk);
  endtask

  initial begin
    logic signed [37:0] y;
    logic signed [37:0] last_y;
    int lat, grp, last_pulse, pulses, seen;
    longint sum_h;

    sum_h = 0;
    for (int k = 0; k < TAPS; k++) sum_h += longint'(h[k]);

    // Stimulus table: impulse, step, full-scale negative, pseudo-random mix.
    model_clear();
    add_vec(0, 16'sh0001);
    for (int i = 1; i < TAPS; i++) add_vec(0, 16'sh0000);
    model_clear();
    for (int i = 0; i < TAPS; i++) add_vec(1, 16'sh0001);
    model_clear();
    for (int i = 0; i < TAPS; i++) add_vec(2, 16'sh8000);
    model_clear();
    for (int i = 0; i < 40; i++) add_vec(3, 16'($urandom));

    rst = 1'b1;
    input_valid = 1'b0;
    FIR_input = '0;
    #12;
    check("reset_out", longint'(FIR_output), 0);
    check("reset_vld", longint'(output_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    grp = -1;
    last_y = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].grp != grp) begin
        do_reset();
        grp = vecs[i].grp;
      end
      send(vecs[i].x, y, lat);
      check($sformatf("vec%0d_grp%0d_y", i, grp), longint'(y), vecs[i].y);
      check($sformatf("vec%0d_lat", i), lat, LAT);
      if (grp == 0 && i == 0) check("impulse_h0", longint'(y), 12);
      if (grp == 1 && i == 2 * TAPS - 1) check("step_sum_h", longint'(y), sum_h);
      if (grp == 2 && i == 3 * TAPS - 1) check("extreme_last", longint'(y), -32768 * sum_h);
      last_y = y;
    end
    input_valid = 1'b0;

    // Output holds after the final result, then a mid-MAC reset aborts cleanly.
    repeat (5) @(negedge clk);
    check("hold_out", longint'(FIR_output), longint'(last_y));
    FIR_input = 16'sh1234;
    input_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", longint'(FIR_output), 0);
    check("midrst_vld", longint'(output_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (output_valid) seen++;
    end
    check("midrst_no_pulse", seen, 0);
    @(negedge clk);
    for (int k = 0; k < TAPS; k++) begin
      send((k == 0) ? 16'sh0001 : 16'sh0000, y, lat);
      check($sformatf("post_rst_imp%0d", k), longint'(y), longint'(h[k]));
    end
    input_valid = 1'b0;

    // Held-high valid: one pulse per TAPS+2 cycles, each sample counted once.
    do_reset();
    model_clear();
    FIR_input = 16'sh0001;
    input_valid = 1'b1;
    last_pulse = -1;
    pulses = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (output_valid) begin
        pulses++;
        check($sformatf("hs_y%0d", pulses), longint'(FIR_output), model_push(1));
        if (last_pulse < 0) check("hs_first_lat", c, LAT);
        else check($sformatf("hs_gap%0d", pulses), c - last_pulse, TAPS + 2);
        last_pulse = c;
      end
    end
    check("hs_pulses", pulses, 6);
    input_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
